// File: rtl/mux_pkg.sv
// Shared constants and helpers for the pipelined N:1 selector.
// Holds the select-width function and the error counter sizing.
// Imported by muxn_pipe and mux_pipe_stage.
package mux_pkg;

  localparam int ERR_CNT_W   = 8;
  localparam int ERR_CNT_MAX = 255;

  // Select width for n inputs; never narrower than one bit.
  function automatic int sel_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_pipe_stage.sv
// One pipeline register holding {data, valid, err}.
// Latency: one cycle. Priority flush > stall > load.
// Stall holds contents; flush clears them even when stalled.
module mux_pipe_stage
  import mux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] d_data,
  input  logic             d_valid,
  input  logic             d_err,
  output logic [WIDTH-1:0] q_data,
  output logic             q_valid,
  output logic             q_err
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  // Next-state: flush empties the stage, stall holds it, otherwise load upstream.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (flush) begin
      data_d  = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else if (!stall) begin
      data_d  = d_data;
      valid_d = d_valid;
      err_d   = d_err;
    end
  end

  // Stage register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign q_data  = data_q;
  assign q_valid = valid_q;
  assign q_err   = err_q;

endmodule

// File: rtl/muxn_pipe.sv
// Pipelined N:1 word selector with out-of-range select reporting.
// Latency: STAGES cycles from capture to out; one word per cycle.
// Stall freezes every stage, flush empties them; optional error counter under MUXN_ERRCNT_EN.
module muxn_pipe
  import mux_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int N_IN   = 3,
  parameter  int STAGES = 1,
  localparam int SEL_W  = sel_width(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  output logic [WIDTH-1:0]      out,
  output logic                  out_valid,
  output logic                  sel_err
`ifdef MUXN_ERRCNT_EN
  ,
  input  logic                  err_clr,
  output logic [ERR_CNT_W-1:0]  err_cnt
`endif
);

  // Stage boundary buses: index 0 is the decoded input, index STAGES the output.
  logic [WIDTH-1:0] stg_data  [STAGES+1];
  logic             stg_valid [STAGES+1];
  logic             stg_err   [STAGES+1];

  logic [WIDTH-1:0] sel_dat;
  logic             sel_oor;

  // Select decode: an unmatched code yields zero data and flags out-of-range.
  always_comb begin
    sel_dat = '0;
    sel_oor = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_dat = in_data[k*WIDTH +: WIDTH];
        sel_oor = 1'b0;
      end
    end
  end

  assign stg_data[0]  = sel_dat;
  assign stg_valid[0] = in_valid;
  assign stg_err[0]   = sel_oor & in_valid;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    mux_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .stall   (stall),
      .flush   (flush),
      .d_data  (stg_data[i]),
      .d_valid (stg_valid[i]),
      .d_err   (stg_err[i]),
      .q_data  (stg_data[i+1]),
      .q_valid (stg_valid[i+1]),
      .q_err   (stg_err[i+1])
    );
  end

  assign out       = stg_data[STAGES];
  assign out_valid = stg_valid[STAGES];
  assign sel_err   = stg_err[STAGES];

`ifdef MUXN_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 err_inc;

  // Counts only words actually captured by stage 0 with a bad select.
  assign err_inc = in_valid & sel_oor & ~stall & ~flush;

  // Next count: clear wins, otherwise saturating increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (err_inc && (err_cnt_q != ERR_CNT_W'(ERR_CNT_MAX))) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_muxn_pipe.sv
module tb_muxn_pipe;

  localparam int WIDTH  = 32;
  localparam int N_IN   = 3;
  localparam int STAGES = 3;

  logic                  clk;
  logic                  rst_n;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [1:0]            sel;
  logic                  in_valid;
  logic                  stall;
  logic                  flush;
  logic [WIDTH-1:0]      out;
  logic                  out_valid;
  logic                  sel_err;
`ifdef MUXN_ERRCNT_EN
  logic                  err_clr;
  logic [7:0]            err_cnt;
`endif

  logic [WIDTH-1:0] w [N_IN];
  assign in_data = {w[2], w[1], w[0]};

  muxn_pipe #(
    .WIDTH  (WIDTH),
    .N_IN   (N_IN),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .stall     (stall),
    .flush     (flush),
    .out       (out),
    .out_valid (out_valid),
    .sel_err   (sel_err)
`ifdef MUXN_ERRCNT_EN
    ,
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted words tagged with the advance count at capture.
  // A word is at the output while the pipe has advanced STAGES-1 more times.
  typedef struct {
    logic [WIDTH-1:0] data;
    logic             err;
    int               at;
  } exp_t;

  exp_t exp_q[$];
  int   adv  = 0;
  int   mcnt = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        adv  = 0;
        mcnt = 0;
      end else begin
        if (flush) begin
          exp_q.delete();
        end else if (!stall) begin
          adv++;
          if (in_valid) begin
            exp_t e;
            if (int'(sel) < N_IN) begin
              e.data = w[sel];
              e.err  = 1'b0;
            end else begin
              e.data = '0;
              e.err  = 1'b1;
            end
            e.at = adv;
            exp_q.push_back(e);
          end
        end
`ifdef MUXN_ERRCNT_EN
        if (err_clr) mcnt = 0;
        else if (!flush && !stall && in_valid && int'(sel) >= N_IN && mcnt < 255) mcnt++;
`endif
      end
    end
  end

  // Monitor: compares the DUT output against the model every falling edge.
  initial begin
    forever begin
      int tgt;
      @(negedge clk);
      tgt = adv - (STAGES - 1);
      while (exp_q.size() > 0 && exp_q[0].at < tgt) void'(exp_q.pop_front());
      if (exp_q.size() > 0 && exp_q[0].at == tgt) begin
        chk("out_valid", 64'(out_valid), 64'(1));
        chk("out", 64'(out), 64'(exp_q[0].data));
        chk("sel_err", 64'(sel_err), 64'(exp_q[0].err));
      end else begin
        chk("out_valid_idle", 64'(out_valid), 64'(0));
        chk("sel_err_idle", 64'(sel_err), 64'(0));
      end
`ifdef MUXN_ERRCNT_EN
      chk("err_cnt", 64'(err_cnt), 64'(mcnt));
`endif
    end
  end

  // Drive one cycle of inputs (called at a falling edge, returns at the next one).
  task automatic cyc(input logic v, input logic [1:0] s, input logic st, input logic fl);
    in_valid = v;
    sel      = s;
    stall    = st;
    flush    = fl;
    @(negedge clk);
  endtask

  task automatic set_words(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    w[0] = a;
    w[1] = b;
    w[2] = c;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sel      = 2'd0;
    stall    = 1'b0;
    flush    = 1'b0;
`ifdef MUXN_ERRCNT_EN
    err_clr  = 1'b0;
`endif
    set_words(32'hAAAA0000, 32'h0000BBBB, 32'h12345678);

    // Reset state while held
    @(negedge clk);
    @(negedge clk);
    chk("rst_out", 64'(out), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_sel_err", 64'(sel_err), 64'(0));
`ifdef MUXN_ERRCNT_EN
    chk("rst_err_cnt", 64'(err_cnt), 64'(0));
`endif
    rst_n = 1'b1;

    // Ordered stream followed by two stall cycles
    cyc(1, 2'd0, 0, 0);
    cyc(1, 2'd1, 0, 0);
    cyc(1, 2'd2, 0, 0);
    cyc(0, 2'd0, 1, 0);
    cyc(1, 2'd1, 1, 0);
    cyc(0, 2'd0, 0, 0);
    chk("stall_mid_word", 64'(out), 64'(32'h0000BBBB));
    cyc(0, 2'd0, 0, 0);
    chk("stall_last_word", 64'(out), 64'(32'h12345678));
    for (int i = 0; i < 3; i++) cyc(0, 2'd0, 0, 0);

    // Out-of-range select
    cyc(1, 2'd3, 0, 0);
    cyc(0, 2'd0, 0, 0);
    cyc(0, 2'd0, 0, 0);
    chk("oor_out", 64'(out), 64'(0));
    chk("oor_sel_err", 64'(sel_err), 64'(1));
    for (int i = 0; i < 3; i++) cyc(0, 2'd0, 0, 0);

    // Flush with stall, pipe full; the word offered that cycle is dropped
    cyc(1, 2'd0, 0, 0);
    cyc(1, 2'd1, 0, 0);
    cyc(1, 2'd2, 0, 0);
    cyc(1, 2'd3, 1, 1);
    chk("flush_out", 64'(out), 64'(0));
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    for (int i = 0; i < 4; i++) cyc(0, 2'd0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_words($urandom, $urandom, $urandom);
`ifdef MUXN_ERRCNT_EN
      err_clr = ($urandom_range(0, 19) == 0);
`endif
      cyc(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
    end
`ifdef MUXN_ERRCNT_EN
    err_clr = 1'b0;
`endif
    set_words(32'hAAAA0000, 32'h0000BBBB, 32'h12345678);
    for (int i = 0; i < 4; i++) cyc(0, 2'd0, 0, 0);

`ifdef MUXN_ERRCNT_EN
    // Counter saturation and clear priority
    err_clr = 1'b1;
    cyc(0, 2'd0, 0, 0);
    err_clr = 1'b0;
    for (int i = 0; i < 260; i++) cyc(1, 2'd3, 0, 0);
    chk("cnt_saturate", 64'(err_cnt), 64'(255));
    err_clr = 1'b1;
    cyc(1, 2'd3, 0, 0);
    err_clr = 1'b0;
    chk("cnt_clear_wins", 64'(err_cnt), 64'(0));
    for (int i = 0; i < 4; i++) cyc(0, 2'd0, 0, 0);
`endif

    // Asynchronous reset with words in flight
    cyc(1, 2'd0, 0, 0);
    cyc(1, 2'd1, 0, 0);
    cyc(1, 2'd2, 0, 0);
    in_valid = 1'b1;
    sel      = 2'd3;
    #7;
    rst_n = 1'b0;
    #1;
    chk("arst_out", 64'(out), 64'(0));
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_sel_err", 64'(sel_err), 64'(0));
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    cyc(1, 2'd2, 0, 0);
    cyc(0, 2'd0, 0, 0);
    chk("post_rst_not_yet", 64'(out_valid), 64'(0));
    cyc(0, 2'd0, 0, 0);
    chk("post_rst_valid", 64'(out_valid), 64'(1));
    chk("post_rst_out", 64'(out), 64'(32'h12345678));
    for (int i = 0; i < 4; i++) cyc(0, 2'd0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muxn_pipe.md
# muxn_pipe

Parametrised, pipelined N:1 datapath selector for the core_lapido pipeline. It is the successor to the fixed three-input combinational selector and is used for operand forwarding and writeback source selection. It selects one of N_IN words with a binary select and carries the result through STAGES register stages with valid, stall and flush control. It reports out-of-range selects and, optionally, counts them.

## Interface
Parameters:
- WIDTH, 32, data word width (1..64)
- N_IN, 3, number of data inputs (2..8)
- STAGES, 1, pipeline register depth (1..4)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_data  in  N_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
- sel  in  SEL_W  binary select, SEL_W = clog2(N_IN)
- in_valid  in  1  qualifies in_data/sel this cycle
- stall  in  1  freeze all stages
- flush  in  1  invalidate all stages
- out  out  WIDTH  selected word at final stage
- out_valid  out  1  out holds a valid result
- sel_err  out  1  result at final stage came from an out-of-range select
- err_clr  in  1  clear error counter (only with MUXN_ERRCNT_EN)
- err_cnt  out  8  saturating error count (only with MUXN_ERRCNT_EN)

## Operation
- Select function, combinational, pre-stage 0: sel < N_IN gives in_data word sel. sel >= N_IN gives all-zero data and err = 1. This matches the legacy 3:1 behaviour, where code 11 produced zero.
- A stage holds {data, valid, err}. Stage 0 loads {selected data, in_valid, err & in_valid}. Stage i loads from stage i-1.
- Priority per cycle: flush > stall > advance.
  - flush=1: every stage goes to valid=0, data=0, err=0, regardless of stall.
  - stall=1, flush=0: every stage holds; inputs are ignored.
  - otherwise: all stages shift by one.
- An invalid input (in_valid=0) still shifts through as a bubble. Its data is the selected word; do not rely on it. Its err is 0.
- out, out_valid and sel_err are driven directly from the final stage registers. No combinational path runs from inputs to outputs.
- Reset (rst_n low, asynchronous): all stages clear to data=0, valid=0, err=0. out=0, out_valid=0, sel_err=0, err_cnt=0.
- Reset mid-stream discards all in-flight words. The first post-reset input appears STAGES cycles after capture.

## Timing
- Latency: an input accepted on edge t (in_valid=1, stall=0, flush=0) appears on out/out_valid after edge t+STAGES-1, so it is visible for STAGES cycles counting the capture cycle. STAGES=1 means a registered output one cycle after presentation.
- Throughput: one word per cycle when not stalled.
- Each stalled cycle adds one cycle of latency to every in-flight word. Order is always preserved.
- A flush asserted on edge t empties the pipe: out_valid=0 after t. An input presented in the flush cycle is dropped.
- Simultaneous stall and flush: the flush takes effect.

## Configuration
- MUXN_ERRCNT_EN defined: err_clr and err_cnt ports exist.
  - err_cnt increments by 1 on each edge where stage 0 captures an err=1 word, meaning in_valid=1, sel>=N_IN, stall=0 and flush=0.
  - err_cnt saturates at 255.
  - err_clr=1 forces 0 on the next edge and wins over a same-cycle increment.
  - err_cnt resets to 0.
- MUXN_ERRCNT_EN undefined: the ports and counter are absent. sel_err behaviour is unchanged.
- When N_IN is a power of two, no select is out of range: err is constant 0 and the counter stays at 0.

## Structure
- Package mux_pkg holds:
  - a sel_width(n) function returning max(1, clog2(n))
  - ERR_CNT_W = 8
  - ERR_CNT_MAX = 255
- One sub-module, mux_pipe_stage: a single {data, valid, err} register with stall/flush priority. muxn_pipe instantiates STAGES of them in a generate loop.
- The select decode and the error counter stay in muxn_pipe.

## Test plan
- Reset/basic: N_IN=3, STAGES=1, in_data words {0xAAAA0000, 0x0000BBBB, 0x12345678}, sel=2, in_valid=1, stall=0, flush=0 -> out=0x12345678, out_valid=1 one cycle later. Out=0, out_valid=0 while rst_n=0.
- Out of range: N_IN=3, sel=3, in_valid=1 -> out=0, out_valid=1, sel_err=1 after STAGES cycles. With MUXN_ERRCNT_EN, err_cnt=1.
- Latency/stall: STAGES=3, stream sel=0,1,2 over 3 cycles, then stall for 2 cycles -> outputs appear in order 0xAAAA0000, 0x0000BBBB, 0x12345678. Total delay for the last word is 3+2 cycles.
- Flush priority: STAGES=3, pipe full, assert stall=1 and flush=1 together -> out_valid=0, out=0 next cycle. A word presented that cycle never appears.
- Counter: MUXN_ERRCNT_EN, 260 consecutive sel=3 accepts -> err_cnt=255. Then err_clr=1 with sel=3 in the same cycle -> err_cnt=0.
- Async reset mid-stream: STAGES=2, drop rst_n between clock edges with valid data in flight -> outputs clear immediately. After release, the next input appears 2 cycles later.
